instr_decode: RTL and testbench
===============================

// Module: instr_decode
// PURPOSE
//  Decode stage directly downstream of instr_fetch/instr_rom. Registers each 9-bit ROM word with its PC.
//  Decodes the registered word and returns Branch/BranchCond/Offset/Halt to instr_fetch.
//  Issues one decoded op per cycle to execute. Stalls on load-use and flag hazards.
//  Squashes the single wrong-path word after a taken branch, and runs the Start/Done handshake.
// PARAMETERS
//  PC_W    16  PC width (matches instr_fetch PC)
//  INSTR_W 9   instruction width (matches instr_rom)
// PORTS
//  CLK          in   1        clock, rising edge
//  Reset        in   1        synchronous, active-high
//  Start        in   1        program start/restart (same wire instr_fetch samples)
//  Instruction  in   INSTR_W  instr_rom output for current PC
//  PC           in   PC_W     instr_fetch PC
//  CondFlag     in   1        execute's registered zero flag
//  Branch       out  1        unconditional branch taken (to fetch)
//  BranchCond   out  1        conditional branch taken (to fetch)
//  Offset       out  8        sign-extended imm6 (to fetch)
//  Halt         out  1        freeze fetch PC (halted, idle, or stall)
//  Done         out  1        program reached HALT
//  Ex_Valid     out  1        Ex_* fields valid this cycle
//  Ex_Op        out  3        opcode
//  Ex_Ra        out  3        ra field
//  Ex_Rb        out  3        rb field
//  Ex_PC        out  PC_W     PC of the issued op
// BEHAVIOUR
//  ISA: op=I[8:6], ra=I[5:3], rb=I[2:0], imm6=I[5:0].
//   000 ADD, 001 SUB, 010 AND, 011 XOR: rd=ra, read ra,rb, write CondFlag.
//   100 LW ra,[rb]: read rb, write ra. 101 SW ra,[rb]: read ra,rb.
//   110 BR imm6. 111 BRC imm6 (taken iff CondFlag=1). 111_000000 = HALT.
//  D register {dv, instr, pc}; EX register {ev, op, ra, rb, pc}. Ex_* driven from EX.
//  FSM IDLE/START/RUN/HALTED. Reset from any state -> IDLE at that edge; dv=ev=0.
//  Reset values: Branch=BranchCond=0, Offset=0, Halt=1, Done=0, Ex_Valid=0, Ex_* fields=0.
//  FSM transitions:
//   IDLE   -> START on Start.
//   START  -> RUN when Start=0. In START, dv<=0 while fetch loads Start_Address.
//   RUN    -> HALTED when HALT sits in D with dv=1. Issues nothing further.
//   HALTED -> START on Start. Done=1 only in HALTED.
//   Start=1 in RUN or HALTED -> START; dv,ev cleared next edge.
//  Halt=1 in IDLE, START and HALTED, and in RUN during a stall. Otherwise 0.
//  RUN, no stall: D<=Instruction/PC with dv=1 each edge; EX<=decode(D), ev=dv.
//  Stall (comb, RUN, dv=1). Holds D, inserts bubble (ev<=0), Halt=1, one cycle per hazard:
//   load-use: EX is LW (ev=1) and D reads EX.ra.
//   flag: D is BRC/HALT-free BRC and EX is an ALU op (ev=1).
//  Branch outputs. Comb from D, gated by dv, RUN, no stall; Offset={I[5],I[5],imm6}, else 0:
//   BR -> Branch=1. BRC with CondFlag=1 -> BranchCond=1.
//  Taken branch: word captured at the same edge is wrong-path; captured with dv=0 (one bubble).
//  Branches and HALT issue ev=0 (not sent to execute).
//  Stall and branch never coexist: a stalled BRC drives both branch outputs 0.
// STRUCTURE
//  isa_pkg: opcode enum, decode_state_t enum, HALT_WORD constant.
//   Field functions: reads_ra, reads_rb, writes_ra, writes_flag.
//  Sub-module hazard_unit (pure comb): D fields + EX op/ra/ev -> stall.
// TESTING
//  Reset mid-RUN with ev=1 -> next cycle Halt=1, Ex_Valid=0, Done=0, state IDLE.
//  Start 1 cyc, ROM[0..2]=ADD r1,r2; SUB r3,r1; HALT:
//   -> Ex_Valid pulses for 2 ops (Ex_PC=0,1) -> Done=1, Halt=1.
//  LW r2,[r0] then ADD r2,r3 -> exactly one stall cycle (Halt=1, bubble), then ADD issues once.
//  BR imm6=6'b111110 at PC=4 -> Branch=1, Offset=8'hFE for 1 cycle.
//   Next D word has dv=0 (no Ex_Valid for PC=5).
//  ADD then BRC: 1-cycle flag stall. CondFlag=0 -> BranchCond=0, fall-through issues.
//   Rerun with CondFlag=1 -> BranchCond=1.
//  Start asserted while HALTED -> START, Done=0.
//   Program re-executes from Start_Address with identical Ex_* trace.

Source files
------------

// File: rtl/isa_pkg.sv
// ISA definitions shared by the decode stage: opcodes, FSM states,
// the HALT encoding and per-opcode register/flag usage helpers.
package isa_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_LW  = 3'b100,
        OP_SW  = 3'b101,
        OP_BR  = 3'b110,
        OP_BRC = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALTED = 2'd3
    } decode_state_t;

    // HALT shares the BRC opcode with a zero immediate
    localparam logic [8:0] HALT_WORD = 9'b111_000000;

    // Decoded view of a 9-bit instruction word
    typedef struct packed {
        opcode_e     op;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [5:0]  imm6;
    } decoded_t;

    function automatic decoded_t decode(input logic [8:0] instr);
        decoded_t d;
        d.op   = opcode_e'(instr[8:6]);
        d.ra   = instr[5:3];
        d.rb   = instr[2:0];
        d.imm6 = instr[5:0];
        return d;
    endfunction

    function automatic logic is_alu(input opcode_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_XOR);
    endfunction

    function automatic logic is_branch(input opcode_e op);
        return (op == OP_BR) || (op == OP_BRC);
    endfunction

    function automatic logic reads_ra(input opcode_e op);
        return is_alu(op) || (op == OP_SW);
    endfunction

    function automatic logic reads_rb(input opcode_e op);
        return is_alu(op) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic writes_ra(input opcode_e op);
        return is_alu(op) || (op == OP_LW);
    endfunction

    function automatic logic writes_flag(input opcode_e op);
        return is_alu(op);
    endfunction

endpackage

// File: rtl/instr_decode_hazard_unit.sv
// Stall detection between the D register and the EX register.
// Load-use: LW in EX whose destination is read by the word in D.
// Flag: conditional branch in D behind an ALU op that has not yet updated CondFlag.
module hazard_unit
    import isa_pkg::*;
(
    input  logic       d_valid,
    input  logic [2:0] d_op,
    input  logic [2:0] d_ra,
    input  logic [2:0] d_rb,
    input  logic       d_is_halt,
    input  logic       ex_valid,
    input  logic [2:0] ex_op,
    input  logic [2:0] ex_ra,
    output logic       stall
);

    opcode_e dop;
    opcode_e eop;
    logic    load_use;
    logic    flag_haz;

    // Combine both hazard sources; only a valid D word can stall
    always_comb begin
        dop      = opcode_e'(d_op);
        eop      = opcode_e'(ex_op);
        load_use = ex_valid && (eop == OP_LW) && writes_ra(eop) &&
                   ((reads_ra(dop) && (d_ra == ex_ra)) ||
                    (reads_rb(dop) && (d_rb == ex_ra)));
        flag_haz = ex_valid && writes_flag(eop) && (dop == OP_BRC) && !d_is_halt;
        stall    = d_valid && (load_use || flag_haz);
    end

endmodule

// File: rtl/instr_decode.sv
// Decode stage: registers the fetched word with its PC (D), decodes it into
// the EX register feeding execute, resolves branches back to fetch, inserts
// hazard bubbles and runs the Start/Done program handshake.
module instr_decode
    import isa_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 9
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Start,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic [PC_W-1:0]    PC,
    input  logic               CondFlag,
    output logic               Branch,
    output logic               BranchCond,
    output logic [7:0]         Offset,
    output logic               Halt,
    output logic               Done,
    output logic               Ex_Valid,
    output logic [2:0]         Ex_Op,
    output logic [2:0]         Ex_Ra,
    output logic [2:0]         Ex_Rb,
    output logic [PC_W-1:0]    Ex_PC
);

    decode_state_t      state_q, state_d;

    // D register
    logic               dv_q, dv_d;
    logic [INSTR_W-1:0] d_instr_q, d_instr_d;
    logic [PC_W-1:0]    d_pc_q, d_pc_d;

    // EX register
    logic               ev_q, ev_d;
    logic [2:0]         ex_op_q, ex_op_d;
    logic [2:0]         ex_ra_q, ex_ra_d;
    logic [2:0]         ex_rb_q, ex_rb_d;
    logic [PC_W-1:0]    ex_pc_q, ex_pc_d;

    decoded_t           d_dec;
    logic               running;
    logic               d_is_halt;
    logic               stall_raw;
    logic               stall;
    logic               br_taken;
    logic               brc_taken;

    // Field decode of the D word and run-state qualifiers
    always_comb begin
        d_dec     = decode(d_instr_q[8:0]);
        running   = (state_q == ST_RUN);
        d_is_halt = dv_q && (d_instr_q[8:0] == HALT_WORD);
    end

    hazard_unit u_hazard (
        .d_valid   (dv_q),
        .d_op      (d_dec.op),
        .d_ra      (d_dec.ra),
        .d_rb      (d_dec.rb),
        .d_is_halt (d_is_halt),
        .ex_valid  (ev_q),
        .ex_op     (ex_op_q),
        .ex_ra     (ex_ra_q),
        .stall     (stall_raw)
    );

    // Branch resolution back to fetch; suppressed while stalled so a stall and
    // a taken branch are never presented together
    always_comb begin
        stall     = running && stall_raw;
        br_taken  = running && dv_q && !stall && (d_dec.op == OP_BR);
        brc_taken = running && dv_q && !stall && (d_dec.op == OP_BRC) &&
                    !d_is_halt && CondFlag;
        Branch     = br_taken;
        BranchCond = brc_taken;
        Offset     = (br_taken || brc_taken) ?
                     {d_dec.imm6[5], d_dec.imm6[5], d_dec.imm6} : 8'h00;
    end

    // Next-state for the FSM, D and EX registers
    always_comb begin
        state_d   = state_q;
        dv_d      = dv_q;
        d_instr_d = d_instr_q;
        d_pc_d    = d_pc_q;
        ev_d      = 1'b0;
        ex_op_d   = ex_op_q;
        ex_ra_d   = ex_ra_q;
        ex_rb_d   = ex_rb_q;
        ex_pc_d   = ex_pc_q;

        unique case (state_q)
            ST_IDLE: begin
                dv_d = 1'b0;
                if (Start) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // fetch is loading its start address; nothing valid to capture
                dv_d = 1'b0;
                if (!Start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Start) begin
                    state_d = ST_START;
                    dv_d    = 1'b0;
                end else if (d_is_halt) begin
                    state_d = ST_HALTED;
                    dv_d    = 1'b0;
                end else if (stall) begin
                    // hold D, bubble into EX
                    ev_d = 1'b0;
                end else begin
                    d_instr_d = Instruction;
                    d_pc_d    = PC;
                    // the word fetched alongside a taken branch is wrong-path
                    dv_d      = !(br_taken || brc_taken);
                    ev_d      = dv_q && !is_branch(d_dec.op);
                    ex_op_d   = d_dec.op;
                    ex_ra_d   = d_dec.ra;
                    ex_rb_d   = d_dec.rb;
                    ex_pc_d   = d_pc_q;
                end
            end
            ST_HALTED: begin
                dv_d = 1'b0;
                if (Start) begin
                    state_d = ST_START;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dv_d    = 1'b0;
            end
        endcase
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            dv_q      <= 1'b0;
            d_instr_q <= '0;
            d_pc_q    <= '0;
            ev_q      <= 1'b0;
            ex_op_q   <= '0;
            ex_ra_q   <= '0;
            ex_rb_q   <= '0;
            ex_pc_q   <= '0;
        end else begin
            state_q   <= state_d;
            dv_q      <= dv_d;
            d_instr_q <= d_instr_d;
            d_pc_q    <= d_pc_d;
            ev_q      <= ev_d;
            ex_op_q   <= ex_op_d;
            ex_ra_q   <= ex_ra_d;
            ex_rb_q   <= ex_rb_d;
            ex_pc_q   <= ex_pc_d;
        end
    end

    // Status and execute-side outputs
    always_comb begin
        Halt     = !running || stall;
        Done     = (state_q == ST_HALTED);
        Ex_Valid = ev_q;
        Ex_Op    = ex_op_q;
        Ex_Ra    = ex_ra_q;
        Ex_Rb    = ex_rb_q;
        Ex_PC    = ex_pc_q;
    end

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode with a small fetch/ROM model driving PC.
module tb_instr_decode;
    import isa_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [8:0]  Instruction;
    logic [15:0] PC;
    logic        CondFlag;
    logic        Branch, BranchCond, Halt, Done, Ex_Valid;
    logic [7:0]  Offset;
    logic [2:0]  Ex_Op, Ex_Ra, Ex_Rb;
    logic [15:0] Ex_PC;

    int compared   = 0;
    int mismatched = 0;

    logic [8:0]  rom [0:63];
    logic [15:0] start_addr;

    instr_decode #(.PC_W(16), .INSTR_W(9)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Instruction(Instruction),
        .PC(PC), .CondFlag(CondFlag), .Branch(Branch), .BranchCond(BranchCond),
        .Offset(Offset), .Halt(Halt), .Done(Done), .Ex_Valid(Ex_Valid),
        .Ex_Op(Ex_Op), .Ex_Ra(Ex_Ra), .Ex_Rb(Ex_Rb), .Ex_PC(Ex_PC)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: fetch model picks the next PC from decode's outputs before the edge
    task automatic tick();
        logic [15:0] nxt;
        @(negedge CLK);
        if (Start)                     nxt = start_addr;
        else if (Branch || BranchCond) nxt = PC + {{8{Offset[7]}}, Offset};
        else if (!Halt)                nxt = PC + 16'd1;
        else                           nxt = PC;
        @(posedge CLK);
        #1;
        PC          = nxt;
        Instruction = rom[PC[5:0]];
        #1;
    endtask

    // Start pulse; returns with FSM in RUN and D empty, fetch PC at addr
    task automatic start_prog(input logic [15:0] addr);
        start_addr = addr;
        Start = 1'b1;
        tick();
        check("start_state", 32'(dut.state_q), 32'(ST_START));
        check("start_done",  32'(Done), 32'd0);
        check("start_halt",  32'(Halt), 32'd1);
        Start = 1'b0;
        tick();
        check("run_state", 32'(dut.state_q), 32'(ST_RUN));
    endtask

    task automatic run_prog_a();
        start_prog(16'd0);
        tick();
        check("a_ev0", 32'(Ex_Valid), 32'd0);
        tick();
        check("a_add_ev", 32'(Ex_Valid), 32'd1);
        check("a_add_op", 32'(Ex_Op), 32'd0);
        check("a_add_ra", 32'(Ex_Ra), 32'd1);
        check("a_add_rb", 32'(Ex_Rb), 32'd2);
        check("a_add_pc", 32'(Ex_PC), 32'd0);
        tick();
        check("a_sub_ev", 32'(Ex_Valid), 32'd1);
        check("a_sub_op", 32'(Ex_Op), 32'd1);
        check("a_sub_ra", 32'(Ex_Ra), 32'd3);
        check("a_sub_rb", 32'(Ex_Rb), 32'd1);
        check("a_sub_pc", 32'(Ex_PC), 32'd1);
        tick();
        check("a_done", 32'(Done), 32'd1);
        check("a_halt", 32'(Halt), 32'd1);
        check("a_ev_end", 32'(Ex_Valid), 32'd0);
    endtask

    task automatic run_brc(input logic cond);
        CondFlag = cond;
        start_prog(16'd16);
        tick();                                   // D = ADD r1,r1
        tick();                                   // EX = ADD, D = BRC -> flag stall
        check("brc_stall_halt", 32'(Halt), 32'd1);
        check("brc_stall_bc",   32'(BranchCond), 32'd0);
        check("brc_stall_br",   32'(Branch), 32'd0);
        check("brc_add_ev",     32'(Ex_Valid), 32'd1);
        tick();                                   // bubble
        check("brc_bub_ev",   32'(Ex_Valid), 32'd0);
        check("brc_res_halt", 32'(Halt), 32'd0);
        check("brc_res_bc",   32'(BranchCond), 32'(cond));
        if (cond) check("brc_off", 32'(Offset), 32'h03);
        tick();
        check("brc_ev_a", 32'(Ex_Valid), 32'd0);
        tick();
        if (!cond) begin
            check("brc_ft_ev", 32'(Ex_Valid), 32'd1);
            check("brc_ft_op", 32'(Ex_Op), 32'd1);
            check("brc_ft_pc", 32'(Ex_PC), 32'd18);
        end else begin
            check("brc_wp_ev", 32'(Ex_Valid), 32'd0);
            tick();
            check("brc_tgt_ev", 32'(Ex_Valid), 32'd1);
            check("brc_tgt_op", 32'(Ex_Op), 32'd3);
            check("brc_tgt_pc", 32'(Ex_PC), 32'd21);
        end
        tick();
        check("brc_done", 32'(Done), 32'd1);
        CondFlag = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = HALT_WORD;
        rom[0]  = 9'b000_001_010;   // ADD r1,r2
        rom[1]  = 9'b001_011_001;   // SUB r3,r1
        rom[4]  = 9'b110_111110;    // BR -2
        rom[5]  = 9'b000_111_111;   // ADD r7,r7 (wrong path)
        rom[8]  = 9'b100_010_000;   // LW r2,[r0]
        rom[9]  = 9'b000_010_011;   // ADD r2,r3
        rom[16] = 9'b000_001_001;   // ADD r1,r1
        rom[17] = 9'b111_000011;    // BRC +3
        rom[18] = 9'b001_010_010;   // SUB r2,r2
        rom[21] = 9'b011_100_101;   // XOR r4,r5

        Reset = 1'b1; Start = 1'b0; CondFlag = 1'b0;
        start_addr = '0; PC = '0; Instruction = rom[0];
        tick();
        tick();
        check("rst_halt", 32'(Halt), 32'd1);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_ev",   32'(Ex_Valid), 32'd0);
        check("rst_br",   32'(Branch), 32'd0);
        check("rst_brc",  32'(BranchCond), 32'd0);
        check("rst_off",  32'(Offset), 32'd0);
        check("rst_exf",  32'({Ex_Op, Ex_Ra, Ex_Rb, Ex_PC}), 32'd0);
        Reset = 1'b0;

        // reset in the middle of a running program
        start_prog(16'd0);
        tick();
        tick();
        check("mid_ev", 32'(Ex_Valid), 32'd1);
        Reset = 1'b1;
        tick();
        check("mid_rst_halt",  32'(Halt), 32'd1);
        check("mid_rst_ev",    32'(Ex_Valid), 32'd0);
        check("mid_rst_done",  32'(Done), 32'd0);
        check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        Reset = 1'b0;
        tick();

        run_prog_a();

        // load-use: LW r2,[r0] ; ADD r2,r3
        start_prog(16'd8);
        tick();
        tick();
        check("lu_lw_ev",  32'(Ex_Valid), 32'd1);
        check("lu_lw_op",  32'(Ex_Op), 32'd4);
        check("lu_lw_pc",  32'(Ex_PC), 32'd8);
        check("lu_stall",  32'(Halt), 32'd1);
        tick();
        check("lu_bub_ev", 32'(Ex_Valid), 32'd0);
        check("lu_unstall", 32'(Halt), 32'd0);
        tick();
        check("lu_add_ev", 32'(Ex_Valid), 32'd1);
        check("lu_add_op", 32'(Ex_Op), 32'd0);
        check("lu_add_pc", 32'(Ex_PC), 32'd9);
        tick();
        check("lu_once",   32'(Ex_Valid), 32'd0);
        check("lu_done",   32'(Done), 32'd1);

        // unconditional branch at PC=4
        start_prog(16'd4);
        tick();
        check("br_taken", 32'(Branch), 32'd1);
        check("br_off",   32'(Offset), 32'hFE);
        check("br_bc",    32'(BranchCond), 32'd0);
        check("br_halt",  32'(Halt), 32'd0);
        tick();
        check("br_pulse", 32'(Branch), 32'd0);
        check("br_noiss", 32'(Ex_Valid), 32'd0);
        tick();
        check("br_squash", 32'(Ex_Valid), 32'd0);
        tick();
        check("br_done",  32'(Done), 32'd1);

        run_brc(1'b0);
        run_brc(1'b1);

        // restart from HALTED replays the same trace
        run_prog_a();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
